// File: rtl/stopwatch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg : shared constants for the stopwatch control slice.
//   - FSM state encodings (PAUSE / RUN / ADJUST)
//   - BCD digit width and digit type
//   - adjust field select constants
//   - f_is_59 : true when a two-digit BCD field reads 59
// -----------------------------------------------------------------------------
package sw_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam logic [1:0] ST_PAUSE = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_ADJ   = 2'd2;

  localparam logic SEL_SEC = 1'b0;
  localparam logic SEL_MIN = 1'b1;

  function automatic logic f_is_59(input bcd_t tens, input bcd_t ones);
    return (tens == 4'd5) && (ones == 4'd9);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_if : control/status bundle of the stopwatch core.
//   i_tick_1hz  1-cycle 1 Hz time-base enable
//   i_tick_adj  1-cycle 2 Hz adjust stepping enable
//   i_pause     1-cycle debounced pause/resume pulse
//   i_adj       level, adjust mode requested
//   i_sel[1:0]  bit0 selects field (0 seconds, 1 minutes); bit1 unused
//   o_val[15:0] BCD {m_tens, m_ones, s_tens, s_ones}
//   o_state     0 PAUSE, 1 RUN, 2 ADJUST
//   o_paused    1 whenever o_state is not RUN
// Modports: master drives the inputs (upstream/bench), slave is the core.
// -----------------------------------------------------------------------------
interface stopwatch_ctrl_if;
  import sw_pkg::*;

  logic               i_tick_1hz;
  logic               i_tick_adj;
  logic               i_pause;
  logic               i_adj;
  logic [1:0]         i_sel;
  logic [4*BCD_W-1:0] o_val;
  logic [1:0]         o_state;
  logic               o_paused;

  modport master (
    output i_tick_1hz, i_tick_adj, i_pause, i_adj, i_sel,
    input  o_val, o_state, o_paused
  );

  modport slave (
    input  i_tick_1hz, i_tick_adj, i_pause, i_adj, i_sel,
    output o_val, o_state, o_paused
  );

endinterface

// File: rtl/stopwatch_ctrl_bcd_mod60.sv
// -----------------------------------------------------------------------------
// bcd_mod60 : two-digit BCD counter, 00..59, wrapping 59 -> 00.
//   clk    in   clock
//   rst    in   asynchronous active-high reset, clears to 00
//   inc    in   advance by one when high
//   tens   out  registered tens digit (0-5)
//   ones   out  registered ones digit (0-9)
//   carry  out  high during the cycle in which inc wraps 59 -> 00, so a
//               chained counter advances on the same edge as the wrap
// -----------------------------------------------------------------------------
module bcd_mod60
  import sw_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output bcd_t tens,
  output bcd_t ones,
  output logic carry
);

  bcd_t r_tens;
  bcd_t r_ones;

  // Two-digit BCD count with ones->tens carry and 59->00 wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (inc) begin
      if (r_ones == 4'd9) begin
        r_ones <= 4'd0;
        r_tens <= (r_tens == 4'd5) ? 4'd0 : r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

  assign tens  = r_tens;
  assign ones  = r_ones;
  assign carry = inc && f_is_59(r_tens, r_ones);

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl : run/pause/adjust sequencer and MM:SS timekeeping core.
//   clk   in   only clock
//   rst   in   asynchronous active-high reset
//   bus   stopwatch_ctrl_if.slave (ticks, pause, adjust, select in;
//         BCD value, state, paused out; all outputs registered)
// Parameters:
//   RST_RUN    1: come out of reset in RUN, 0: in PAUSE
//   ADJ_CARRY  1: adjust-mode seconds wrap carries into minutes
// Build option STOPWATCH_STOP_AT_MAX_EN: a RUN tick at 59:59 holds the value
// and drops to PAUSE instead of rolling over to 00:00.
// -----------------------------------------------------------------------------
module stopwatch_ctrl
  import sw_pkg::*;
#(
  parameter int RST_RUN   = 0,
  parameter int ADJ_CARRY = 0
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_RST = (RST_RUN != 0) ? ST_RUN : ST_PAUSE;

  logic [1:0] r_state;
  logic       r_paused;
  logic [1:0] w_state_nxt;
  logic       w_sec_inc;
  logic       w_min_inc;
  logic       w_sec_carry;
  logic       w_min_carry_unused;
  logic       w_sel_unused;
  logic       w_clamp;
  bcd_t       w_sec_tens, w_sec_ones, w_min_tens, w_min_ones;

  assign w_sel_unused = bus.i_sel[1];

`ifdef STOPWATCH_STOP_AT_MAX_EN
  // A RUN tick that would roll 59:59 over is swallowed and forces PAUSE.
  assign w_clamp = (r_state == ST_RUN) && bus.i_tick_1hz &&
                   f_is_59(w_min_tens, w_min_ones) &&
                   f_is_59(w_sec_tens, w_sec_ones);
`else
  assign w_clamp = 1'b0;
`endif

  // Increment steering: the current state decides which field advances.
  always_comb begin
    w_sec_inc = 1'b0;
    w_min_inc = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_sec_inc = bus.i_tick_1hz && !w_clamp;
        w_min_inc = w_sec_carry;
      end
      ST_ADJ: begin
        if (bus.i_sel[0] == SEL_MIN) begin
          w_min_inc = bus.i_tick_adj;
        end else begin
          w_sec_inc = bus.i_tick_adj;
          w_min_inc = (ADJ_CARRY != 0) ? w_sec_carry : 1'b0;
        end
      end
      default: begin
        w_sec_inc = 1'b0;
        w_min_inc = 1'b0;
      end
    endcase
  end

  // Next-state logic; adjust request overrides everything, pause is ignored in ADJUST.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.i_adj) begin
      w_state_nxt = ST_ADJ;
    end else begin
      case (r_state)
        ST_PAUSE: w_state_nxt = bus.i_pause ? ST_RUN : ST_PAUSE;
        ST_RUN:   w_state_nxt = (bus.i_pause || w_clamp) ? ST_PAUSE : ST_RUN;
        ST_ADJ:   w_state_nxt = ST_PAUSE;
        default:  w_state_nxt = ST_PAUSE;
      endcase
    end
  end

  // State and paused flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RST;
      r_paused <= (ST_RST != ST_RUN);
    end else begin
      r_state  <= w_state_nxt;
      r_paused <= (w_state_nxt != ST_RUN);
    end
  end

  bcd_mod60 u_sec (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_sec_inc),
    .tens  (w_sec_tens),
    .ones  (w_sec_ones),
    .carry (w_sec_carry)
  );

  // Minutes never carry onward; 59:59 rolls to 00:00 through the natural wrap.
  bcd_mod60 u_min (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_min_inc),
    .tens  (w_min_tens),
    .ones  (w_min_ones),
    .carry (w_min_carry_unused)
  );

  assign bus.o_val    = {w_min_tens, w_min_ones, w_sec_tens, w_sec_ones};
  assign bus.o_state  = r_state;
  assign bus.o_paused = r_paused;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl : directed bench for stopwatch_ctrl (RST_RUN=0,
// ADJ_CARRY=0). Inputs change 1 time unit after a rising edge and outputs are
// sampled at the same point, so each value seen reflects the last edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl_if u_if ();

  stopwatch_ctrl #(.RST_RUN(0), .ADJ_CARRY(0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 16'h%h, expected 16'h%h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick(input int n);
    repeat (n) begin
      u_if.i_tick_1hz = 1'b1; step(); u_if.i_tick_1hz = 1'b0;
    end
  endtask

  task automatic pulse_adj(input int n);
    repeat (n) begin
      u_if.i_tick_adj = 1'b1; step(); u_if.i_tick_adj = 1'b0;
    end
  endtask

  task automatic pulse_pause();
    u_if.i_pause = 1'b1; step(); u_if.i_pause = 1'b0;
  endtask

  task automatic do_reset();
    u_if.i_adj = 1'b0; u_if.i_sel = 2'b00;
    rst = 1'b1; step(); rst = 1'b0; step();
  endtask

  // Enter ADJUST from 00:00 and step seconds then minutes to the target.
  task automatic adj_load(input int m, input int s);
    u_if.i_adj = 1'b1; u_if.i_sel = 2'b00; step();
    pulse_adj(s);
    u_if.i_sel = 2'b01;
    pulse_adj(m);
  endtask

  task automatic go_run();
    u_if.i_adj = 1'b0; step();
    pulse_pause();
  endtask

  initial begin
    u_if.i_tick_1hz = 1'b0; u_if.i_tick_adj = 1'b0; u_if.i_pause = 1'b0;
    u_if.i_adj = 1'b0; u_if.i_sel = 2'b00;
    #1 rst = 1'b1;
    #1;
    check_val("rst_val",    u_if.o_val, 16'h0000);
    check_val("rst_state",  {14'd0, u_if.o_state}, 16'd0);
    check_val("rst_paused", {15'd0, u_if.o_paused}, 16'd1);
    step(); rst = 1'b0; step();

    pulse_tick(5);
    check_val("pause_val",    u_if.o_val, 16'h0000);
    check_val("pause_state",  {14'd0, u_if.o_state}, 16'd0);
    check_val("pause_paused", {15'd0, u_if.o_paused}, 16'd1);

    pulse_pause();
    check_val("run_state",  {14'd0, u_if.o_state}, 16'd1);
    check_val("run_paused", {15'd0, u_if.o_paused}, 16'd0);
    pulse_tick(60);
    check_val("run_60", u_if.o_val, 16'h0100);
    pulse_tick(1);
    check_val("run_61",       u_if.o_val, 16'h0101);
    check_val("run_61_state", {14'd0, u_if.o_state}, 16'd1);

    do_reset();
    adj_load(59, 59);
    check_val("load_5959",  u_if.o_val, 16'h5959);
    check_val("load_state", {14'd0, u_if.o_state}, 16'd2);
    go_run();
    check_val("max_run_state", {14'd0, u_if.o_state}, 16'd1);
    pulse_tick(1);
`ifdef STOPWATCH_STOP_AT_MAX_EN
    check_val("max_val",    u_if.o_val, 16'h5959);
    check_val("max_state",  {14'd0, u_if.o_state}, 16'd0);
    check_val("max_paused", {15'd0, u_if.o_paused}, 16'd1);
    pulse_pause();
    check_val("max_rerun_state", {14'd0, u_if.o_state}, 16'd1);
    pulse_tick(1);
    check_val("max_rerun_val",   u_if.o_val, 16'h5959);
    check_val("max_rerun_pause", {14'd0, u_if.o_state}, 16'd0);
`else
    check_val("max_val",    u_if.o_val, 16'h0000);
    check_val("max_state",  {14'd0, u_if.o_state}, 16'd1);
    check_val("max_paused", {15'd0, u_if.o_paused}, 16'd0);
    pulse_tick(1);
    check_val("wrap_next", u_if.o_val, 16'h0001);
`endif

    do_reset();
    adj_load(58, 10);
    check_val("load_5810", u_if.o_val, 16'h5810);
    u_if.i_sel = 2'b01;
    pulse_adj(3);
    check_val("adj_min_wrap", u_if.o_val, 16'h0110);
    u_if.i_sel = 2'b10;
    pulse_adj(1);
    check_val("adj_sel_bit1", u_if.o_val, 16'h0111);
    pulse_pause();
    check_val("adj_pause_ign", {14'd0, u_if.o_state}, 16'd2);
    u_if.i_sel = 2'b00;
    pulse_adj(49);
    check_val("adj_sec_nocarry", u_if.o_val, 16'h0100);
    pulse_tick(2);
    check_val("adj_1hz_ign", u_if.o_val, 16'h0100);
    u_if.i_adj = 1'b0; step();
    check_val("adj_exit_state",  {14'd0, u_if.o_state}, 16'd0);
    check_val("adj_exit_paused", {15'd0, u_if.o_paused}, 16'd1);

    do_reset();
    adj_load(0, 9);
    go_run();
    check_val("sim_pre_val", u_if.o_val, 16'h0009);
    u_if.i_tick_1hz = 1'b1; u_if.i_pause = 1'b1; step();
    u_if.i_tick_1hz = 1'b0; u_if.i_pause = 1'b0;
    check_val("sim_pause_val",   u_if.o_val, 16'h0010);
    check_val("sim_pause_state", {14'd0, u_if.o_state}, 16'd0);
    pulse_pause();
    u_if.i_tick_1hz = 1'b1; u_if.i_adj = 1'b1; step();
    u_if.i_tick_1hz = 1'b0;
    check_val("sim_adj_val",   u_if.o_val, 16'h0011);
    check_val("sim_adj_state", {14'd0, u_if.o_state}, 16'd2);
    u_if.i_adj = 1'b0; step();

    do_reset();
    adj_load(9, 59);
    go_run();
    pulse_tick(1);
    check_val("carry_0959", u_if.o_val, 16'h1000);

    do_reset();
    adj_load(12, 34);
    go_run();
    check_val("arst_pre_val",   u_if.o_val, 16'h1234);
    check_val("arst_pre_state", {14'd0, u_if.o_state}, 16'd1);
    #3 rst = 1'b1;
    #1;
    check_val("arst_val",    u_if.o_val, 16'h0000);
    check_val("arst_state",  {14'd0, u_if.o_state}, 16'd0);
    check_val("arst_paused", {15'd0, u_if.o_paused}, 16'd1);
    step(); rst = 1'b0; step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
